// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings, FSM state types and burst next-address arithmetic
// for the SRAM-backed AXI4 slave.
package axi4_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rd_state_e;

    // Computed at 64 bits so any address port width up to 64 can share it.
    function automatic logic [63:0] axi_next_addr(input logic [63:0] addr, input logic [7:0] len,
                                                  input logic [2:0] size, input logic [1:0] burst);
        logic [63:0] incr;
        logic [63:0] bmask;
        incr  = 64'd1 << size;
        bmask = ((64'(len) + 64'd1) << size) - 64'd1;
        case (burst)
            BURST_FIXED: return addr;
            BURST_WRAP:  return (addr & ~bmask) | ((addr + incr) & bmask);
            default:     return addr + incr;
        endcase
    endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Per-channel burst address stepper and request legality check.
// Upper-address range checking is enabled by defining AXI_SLV_RANGE_CHECK_EN.
module axi4_burst_addr_gen import axi4_pkg::*; #(
    parameter int DW    = 32,
    parameter int AW    = 18,
    parameter int ADDRW = 32
) (
    input  logic [ADDRW-1:0] addr_i,
    input  logic [7:0]       len_i,
    input  logic [2:0]       size_i,
    input  logic [1:0]       burst_i,
    output logic [ADDRW-1:0] next_addr_o,
    output logic             err_o
);
    localparam int OFFS = $clog2(DW/8);
`ifdef AXI_SLV_RANGE_CHECK_EN
    localparam logic RANGE_CHK = 1'b1;
`else
    localparam logic RANGE_CHK = 1'b0;
`endif

    logic wrap_len_ok;
    logic range_err;

    assign next_addr_o = ADDRW'(axi_next_addr(64'(addr_i), len_i, size_i, burst_i));
    assign wrap_len_ok = (len_i == 8'd1) || (len_i == 8'd3) || (len_i == 8'd7) || (len_i == 8'd15);
    assign range_err   = RANGE_CHK && (|addr_i[ADDRW-1:AW]);
    assign err_o       = (int'(size_i) > OFFS) || ((burst_i == BURST_WRAP) && !wrap_len_ok) || range_err;

endmodule

// File: rtl/axi4_slv_sram_burst.sv
// AXI4 full slave over an inferred 1R1W SRAM (array "ram", backdoor-preloadable).
// Independent read/write FSMs, one burst each. Optional AXI_SLV_RANGE_CHECK_EN.
module axi4_slv_sram_burst import axi4_pkg::*; #(
    parameter int DW    = 32,
    parameter int AW    = 18,
    parameter int IDW   = 4,
    parameter int ADDRW = 32
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic [IDW-1:0]   MEM_AWID,
    input  logic [ADDRW-1:0] MEM_AWADDR,
    input  logic [7:0]       MEM_AWLEN,
    input  logic [2:0]       MEM_AWSIZE,
    input  logic [1:0]       MEM_AWBURST,
    input  logic             MEM_AWVALID,
    output logic             MEM_AWREADY,
    input  logic [DW-1:0]    MEM_WDATA,
    input  logic [DW/8-1:0]  MEM_WSTRB,
    input  logic             MEM_WLAST,
    input  logic             MEM_WVALID,
    output logic             MEM_WREADY,
    output logic [IDW-1:0]   MEM_BID,
    output logic [1:0]       MEM_BRESP,
    output logic             MEM_BVALID,
    input  logic             MEM_BREADY,
    input  logic [IDW-1:0]   MEM_ARID,
    input  logic [ADDRW-1:0] MEM_ARADDR,
    input  logic [7:0]       MEM_ARLEN,
    input  logic [2:0]       MEM_ARSIZE,
    input  logic [1:0]       MEM_ARBURST,
    input  logic             MEM_ARVALID,
    output logic             MEM_ARREADY,
    output logic [IDW-1:0]   MEM_RID,
    output logic [DW-1:0]    MEM_RDATA,
    output logic [1:0]       MEM_RRESP,
    output logic             MEM_RLAST,
    output logic             MEM_RVALID,
    input  logic             MEM_RREADY
);
    localparam int NB   = DW/8;
    localparam int OFFS = $clog2(NB);
    localparam int DP   = (2**AW)/NB;

    logic [DW-1:0] ram [DP];

    wr_state_e        w_state_q, w_state_d;
    rd_state_e        r_state_q, r_state_d;
    logic             live_q;
    logic [IDW-1:0]   aw_id_q, ar_id_q;
    logic [ADDRW-1:0] aw_addr_q, ar_addr_q, wg_next, rg_next;
    logic [7:0]       aw_len_q, ar_len_q, w_cnt_q, r_cnt_q;
    logic [2:0]       aw_size_q, ar_size_q;
    logic [1:0]       aw_burst_q, ar_burst_q;
    logic             w_bad_q, w_last_err_q, r_bad_q, wg_err, rg_err;
    logic [DW-1:0]    rdata_q;
    logic             w_idle, r_idle, aw_hs, w_hs, ar_hs, r_hs, w_last_beat, r_last_beat, ram_we;

    assign w_idle      = (w_state_q == W_IDLE);
    assign r_idle      = (r_state_q == R_IDLE);
    assign MEM_AWREADY = live_q && w_idle;
    assign MEM_WREADY  = (w_state_q == W_DATA);
    assign MEM_BVALID  = (w_state_q == W_RESP);
    assign MEM_BID     = aw_id_q;
    assign MEM_BRESP   = (w_bad_q || w_last_err_q) ? RESP_SLVERR : RESP_OKAY;
    assign MEM_ARREADY = live_q && r_idle;
    assign MEM_RVALID  = (r_state_q == R_DATA);
    assign MEM_RID     = ar_id_q;
    assign MEM_RDATA   = rdata_q;
    assign MEM_RRESP   = r_bad_q ? RESP_SLVERR : RESP_OKAY;
    assign MEM_RLAST   = MEM_RVALID && r_last_beat;

    assign aw_hs       = MEM_AWVALID && MEM_AWREADY;
    assign w_hs        = MEM_WVALID && MEM_WREADY;
    assign ar_hs       = MEM_ARVALID && MEM_ARREADY;
    assign r_hs        = MEM_RVALID && MEM_RREADY;
    assign w_last_beat = (w_cnt_q == aw_len_q);
    assign r_last_beat = (r_cnt_q == ar_len_q);
    assign ram_we      = RSTn && w_hs && !w_bad_q;

    // While idle the generator checks the incoming request; afterwards it steps the latched burst.
    axi4_burst_addr_gen #(.DW(DW), .AW(AW), .ADDRW(ADDRW)) u_wr_gen (
        .addr_i(w_idle ? MEM_AWADDR : aw_addr_q), .len_i(w_idle ? MEM_AWLEN : aw_len_q),
        .size_i(w_idle ? MEM_AWSIZE : aw_size_q), .burst_i(w_idle ? MEM_AWBURST : aw_burst_q),
        .next_addr_o(wg_next), .err_o(wg_err)
    );

    axi4_burst_addr_gen #(.DW(DW), .AW(AW), .ADDRW(ADDRW)) u_rd_gen (
        .addr_i(r_idle ? MEM_ARADDR : ar_addr_q), .len_i(r_idle ? MEM_ARLEN : ar_len_q),
        .size_i(r_idle ? MEM_ARSIZE : ar_size_q), .burst_i(r_idle ? MEM_ARBURST : ar_burst_q),
        .next_addr_o(rg_next), .err_o(rg_err)
    );

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (aw_hs) w_state_d = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_state_d = W_RESP;
            W_RESP:  if (MEM_BREADY) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs) r_state_d = R_FETCH;
            R_FETCH: r_state_d = R_DATA;
            R_DATA:  if (r_hs) r_state_d = r_last_beat ? R_IDLE : R_FETCH;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            live_q       <= 1'b0;
            w_state_q    <= W_IDLE;
            aw_id_q      <= '0;
            aw_addr_q    <= '0;
            aw_len_q     <= '0;
            aw_size_q    <= '0;
            aw_burst_q   <= '0;
            w_cnt_q      <= '0;
            w_bad_q      <= 1'b0;
            w_last_err_q <= 1'b0;
        end else begin
            live_q    <= 1'b1;
            w_state_q <= w_state_d;
            if (aw_hs) begin
                aw_id_q      <= MEM_AWID;
                aw_addr_q    <= MEM_AWADDR;
                aw_len_q     <= MEM_AWLEN;
                aw_size_q    <= MEM_AWSIZE;
                aw_burst_q   <= MEM_AWBURST;
                w_cnt_q      <= '0;
                w_bad_q      <= wg_err;
                w_last_err_q <= 1'b0;
            end
            if (w_hs) begin
                if (MEM_WLAST != w_last_beat) w_last_err_q <= 1'b1;
                if (!w_last_beat) begin
                    aw_addr_q <= wg_next;
                    w_cnt_q   <= w_cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (ram_we) begin
            for (int b = 0; b < NB; b++)
                if (MEM_WSTRB[b]) ram[aw_addr_q[AW-1:OFFS]][b*8 +: 8] <= MEM_WDATA[b*8 +: 8];
        end
    end

    // rdata_q only loads in R_FETCH, so it stays put while the master stalls R.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state_q  <= R_IDLE;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            r_cnt_q    <= '0;
            r_bad_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            r_state_q <= r_state_d;
            if (ar_hs) begin
                ar_id_q    <= MEM_ARID;
                ar_addr_q  <= MEM_ARADDR;
                ar_len_q   <= MEM_ARLEN;
                ar_size_q  <= MEM_ARSIZE;
                ar_burst_q <= MEM_ARBURST;
                r_cnt_q    <= '0;
                r_bad_q    <= rg_err;
            end
            if (r_state_q == R_FETCH) rdata_q <= r_bad_q ? '0 : ram[ar_addr_q[AW-1:OFFS]];
            if (r_hs && !r_last_beat) begin
                ar_addr_q <= rg_next;
                r_cnt_q   <= r_cnt_q + 8'd1;
            end
        end
    end

endmodule
